uart_rx_bram_wr: RTL and testbench
==================================

// Module: uart_rx_bram_wr
// PURPOSE
//  UART receive front end of the uart_bram design: deserialises 8-bit frames from the rx pin
//  and writes each good byte into the BRAM write port at an auto-incrementing address.
//  Sits between the board rx pin and the BRAM instance; the tx/readback path consumes the BRAM.
// PARAMETERS
//  CLK_FREQ   100_000_000  system clock frequency, Hz
//  BAUD       115_200      line rate; bit period BIT_CYC = CLK_FREQ/BAUD (868 at defaults)
//  ADDR_W     4            BRAM address width; depth 2**ADDR_W bytes
// PORTS
//  sys_clk     in   1         system clock, single clock domain
//  sys_rst     in   1         asynchronous, active-high reset
//  rx          in   1         asynchronous serial input, idle high
//  bram_we     out  1         one-cycle write strobe
//  bram_addr   out  ADDR_W    write address, valid while bram_we=1
//  bram_din    out  8         write data, valid while bram_we=1
//  frame_err   out  1         one-cycle pulse: stop bit (or parity) bad, byte dropped
//  byte_cnt    out  ADDR_W+1  bytes written since reset, saturates at 2**ADDR_W
// BEHAVIOUR
//  - Reset: all outputs 0, write pointer 0, FSM IDLE, rx sync flops set to 1.
//  - rx passes a 2-FF synchroniser; all decisions use the synchronised value rx_s.
//  - Baud counter counts 0..BIT_CYC-1; HALF = BIT_CYC/2.
//  - FSM IDLE: falling edge of rx_s (prev 1, now 0) -> START, counter cleared.
//  - START: at count HALF sample rx_s; 1 = glitch -> IDLE (no outputs); 0 -> DATA, counter cleared.
//  - DATA: at count BIT_CYC-1 sample one bit, LSB first, into shift register; after bit 7 -> STOP
//    (or PARITY if enabled). Samples land mid-bit because START re-aligned at half bit.
//  - STOP: at count BIT_CYC-1 sample rx_s. 1 -> next cycle bram_we=1, bram_din=byte,
//    bram_addr=wr_ptr; wr_ptr increments after the write. 0 -> frame_err pulse, no write,
//    wr_ptr unchanged. Either way -> IDLE in the same cycle as the sample (mid stop bit), so
//    a back-to-back start edge is caught.
//  - After a bad stop, a line held low does not retrigger: IDLE needs a 1->0 edge.
//  - wr_ptr wraps 2**ADDR_W-1 -> 0 and overwrites old data; byte_cnt saturates at 2**ADDR_W.
//  - Latency: bram_we rises 1 cycle after the stop sample, ~9.5 bit times + 3 cycles after
//    the start edge on the rx pin.
//  - bram_we and frame_err are never high in the same cycle; each is high at most 1 cycle/frame.
//  - Reset mid-frame: partial byte discarded, no write, next frame goes to address 0.
// CONFIGURATION
//  UART_RX_PARITY_EN defined: frame is 8E1. An extra PARITY state follows DATA and samples
//    one bit period later. A byte is written only if parity is even AND the stop bit is 1;
//    otherwise frame_err pulses at the stop sample.
//  Undefined: 8N1, no PARITY state, parity logic absent.
// STRUCTURE
//  - Shared package/header uart_pkg: FSM state encodings (IDLE, START, DATA, PARITY, STOP),
//    BIT_CYC/HALF calculation macro, default CLK_FREQ/BAUD constants.
//  - One natural sub-module: uart_baud_tick (counter with clear, emits half and full ticks),
//    reusable by the tx side.
//  - The write-pointer/byte_cnt logic stays inline.
// TESTING  (100 MHz, bit period 8680 ns)
//  - Send 0x00..0x0F back to back: 16 bram_we pulses, addr i, din i, byte_cnt=16, no frame_err.
//  - Send 0xA5 after reset: single bram_we, addr 0, din 0xA5; bits sampled mid-bit
//    (check at start edge + 1.5 bit times for bit 0).
//  - Low glitch of 100 ns on idle line: FSM returns to IDLE, no bram_we, no frame_err.
//  - Frame 0x3C with stop bit driven 0: frame_err pulse, no bram_we, next good byte at the
//    previous wr_ptr.
//  - 17 bytes with ADDR_W=4: 17th writes addr 0; byte_cnt stays 16.
//  - sys_rst pulsed during bit 4 of a frame: outputs 0 immediately; next byte 0x55 writes
//    addr 0. With UART_RX_PARITY_EN, wrong parity on 0x01 -> frame_err, no write.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, default line constants and bit-period math.
// Used by both the rx front end and the baud tick generator.
`ifndef UART_PKG_SV
`define UART_PKG_SV

`define UART_BIT_CYC(clk_hz, baud) ((clk_hz) / (baud))

package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ = 100_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  function automatic int unsigned bit_cyc(input int unsigned clk_hz, input int unsigned baud);
    return `UART_BIT_CYC(clk_hz, baud);
  endfunction

endpackage

`endif

// File: rtl/uart_baud_tick.sv
// Bit-period counter 0..BIT_CYC-1 with synchronous clear; flags the half-bit and last-cycle counts.
// Zero latency (flags decode the current count); no backpressure, free-running unless cleared.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYC = bit_cyc(DEF_CLK_FREQ, DEF_BAUD)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic half_o,
  output logic full_o
);

  localparam int unsigned    CW   = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 1;
  localparam logic [CW-1:0]  HALF = CW'(BIT_CYC / 2);
  localparam logic [CW-1:0]  LAST = CW'(BIT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign half_o = (cnt_q == HALF);
  assign full_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_bram_wr.sv
// UART 8N1 receiver writing each good byte to a BRAM port at an auto-incrementing address (8E1 when UART_RX_PARITY_EN is defined).
// Latency: bram_we one cycle after the mid-stop-bit sample; no backpressure, the BRAM port must accept every strobe.
module uart_rx_bram_wr
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rx,
  output logic              bram_we,
  output logic [ADDR_W-1:0] bram_addr,
  output logic [7:0]        bram_din,
  output logic              frame_err,
  output logic [ADDR_W:0]   byte_cnt
);

  localparam int unsigned   BIT_CYC = bit_cyc(CLK_FREQ, BAUD);
  localparam logic [ADDR_W:0] CNT_MAX = (ADDR_W+1)'(2 ** ADDR_W);

  logic              rx_meta_q, rx_s_q, rx_prev_q;
  uart_state_e       state_q, state_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              we_q, we_d;
  logic              ferr_q, ferr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        din_q, din_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              tick_clr, tick_half, tick_full;
  logic              frame_ok;

  uart_baud_tick #(.BIT_CYC(BIT_CYC)) u_baud_tick (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .clr_i  (tick_clr),
    .half_o (tick_half),
    .full_o (tick_full)
  );

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  // Even parity: data bits plus parity bit must XOR to zero.
  assign frame_ok = rx_s_q && !(^shift_q ^ par_q);
`else
  assign frame_ok = rx_s_q;
`endif

  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    we_d      = 1'b0;
    ferr_d    = 1'b0;
    addr_d    = addr_q;
    din_d     = din_q;
    wr_ptr_d  = wr_ptr_q;
    cnt_d     = cnt_q;
    tick_clr  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_s_q) begin
          state_d  = ST_START;
          tick_clr = 1'b1;
        end
      end
      ST_START: begin
        // Re-aligning the counter at half a bit puts every later full tick mid-bit.
        if (tick_half) begin
          if (rx_s_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d   = ST_DATA;
            tick_clr  = 1'b1;
            bit_idx_d = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (tick_full) begin
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (tick_full) begin
          par_d   = rx_s_q;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (tick_full) begin
          state_d = ST_IDLE;
          if (frame_ok) begin
            we_d     = 1'b1;
            addr_d   = wr_ptr_q;
            din_d    = shift_q;
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
            if (cnt_q != CNT_MAX) cnt_d = cnt_q + (ADDR_W+1)'(1);
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= ST_IDLE;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      we_q      <= 1'b0;
      ferr_q    <= 1'b0;
      addr_q    <= '0;
      din_q     <= 8'd0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      we_q      <= we_d;
      ferr_q    <= ferr_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  assign bram_we   = we_q;
  assign frame_err = ferr_q;
  assign bram_addr = addr_q;
  assign bram_din  = din_q;
  assign byte_cnt  = cnt_q;

endmodule

// File: tb/tb_uart_rx_bram_wr.sv
// Bench for uart_rx_bram_wr at a 16-cycle bit period; the event queue holds the writes/errors each sent frame must produce.
module tb_uart_rx_bram_wr;

  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int          BIT      = 16;
  localparam int          ADDR_W   = 4;
  localparam int          DEPTH    = 16;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              rx      = 1'b1;
  logic              bram_we;
  logic [ADDR_W-1:0] bram_addr;
  logic [7:0]        bram_din;
  logic              frame_err;
  logic [ADDR_W:0]   byte_cnt;

  uart_rx_bram_wr #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .rx        (rx),
    .bram_we   (bram_we),
    .bram_addr (bram_addr),
    .bram_din  (bram_din),
    .frame_err (frame_err),
    .byte_cnt  (byte_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    bit         is_err;
    logic [3:0] addr;
    logic [7:0] data;
  } ev_t;

  ev_t        exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         exp_ptr = 0;
  int         exp_cnt = 0;
  int         n_writes = 0;
  int         n_errs = 0;
  logic [3:0] last_addr = 4'd0;
  logic [7:0] last_din = 8'd0;
  int         cyc = 0;
  int         start_cyc = 0;
  int         last_we_cyc = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Compare process: every cycle out of reset, outputs must match the queued model events.
  initial begin
    ev_t e;
    forever begin
      @(posedge sys_clk);
      #2;
      if (!sys_rst) begin
        check("we_err_exclusive", 32'(bram_we & frame_err), 0);
        if (bram_we) begin
          n_writes++;
          last_addr   = bram_addr;
          last_din    = bram_din;
          last_we_cyc = cyc;
          check("we_has_expected_event", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("we_event_kind", 32'(e.is_err), 0);
            check("bram_addr", 32'(bram_addr), 32'(e.addr));
            check("bram_din", 32'(bram_din), 32'(e.data));
          end
          exp_cnt = (exp_cnt < DEPTH) ? exp_cnt + 1 : DEPTH;
        end
        if (frame_err) begin
          n_errs++;
          check("err_has_expected_event", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("err_event_kind", 32'(e.is_err), 1);
          end
        end
        check("byte_cnt", 32'(byte_cnt), exp_cnt);
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge sys_clk);
    rx = b;
    repeat (BIT - 1) @(negedge sys_clk);
  endtask

  task automatic idle(input int n);
    @(negedge sys_clk);
    rx = 1'b1;
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop, input bit bad_par);
    ev_t e;
    bit  good;
`ifdef UART_RX_PARITY_EN
    good = stop && !bad_par;
`else
    good = stop;
`endif
    e.is_err = !good;
    e.addr   = good ? 4'(exp_ptr) : 4'd0;
    e.data   = good ? d : 8'd0;
    exp_q.push_back(e);
    if (good) exp_ptr = (exp_ptr + 1) % DEPTH;
    @(negedge sys_clk);
    rx = 1'b0;
    start_cyc = cyc;
    repeat (BIT - 1) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bram_we"}, 32'(bram_we), 0);
    check({tag, "_frame_err"}, 32'(frame_err), 0);
    check({tag, "_bram_addr"}, 32'(bram_addr), 0);
    check({tag, "_bram_din"}, 32'(bram_din), 0);
    check({tag, "_byte_cnt"}, 32'(byte_cnt), 0);
  endtask

  task automatic do_reset(input string tag);
    @(negedge sys_clk);
    sys_rst = 1'b1;
    rx      = 1'b1;
    exp_q.delete();
    exp_ptr = 0;
    exp_cnt = 0;
    #1;
    check_outputs_zero(tag);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  initial begin
    int w0, e0, lat;

    #1;
    check_outputs_zero("por");
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);

    // Single byte: 0xA5 lands at address 0, strobe about 9.5 bit times after the start edge.
    w0 = n_writes;
    send_frame(8'hA5, 1'b1, 1'b0);
    lat = last_we_cyc - start_cyc;
    idle(2 * BIT);
    check("a5_writes", n_writes - w0, 1);
    check("a5_addr", 32'(last_addr), 0);
    check("a5_din", 32'(last_din), 32'hA5);
    check("a5_latency_window", 32'(lat >= 152 && lat <= 162), 1);
    check("a5_pending", exp_q.size(), 0);

    // Short low glitch on an idle line: nothing happens.
    w0 = n_writes;
    e0 = n_errs;
    @(negedge sys_clk);
    rx = 1'b0;
    repeat (4) @(negedge sys_clk);
    idle(3 * BIT);
    check("glitch_writes", n_writes - w0, 0);
    check("glitch_errs", n_errs - e0, 0);

    // Bad stop bit, line then held low: one error, no retrigger; next byte reuses the pointer.
    w0 = n_writes;
    e0 = n_errs;
    send_frame(8'h3C, 1'b0, 1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    idle(2 * BIT);
    check("badstop_errs", n_errs - e0, 1);
    check("badstop_writes", n_writes - w0, 0);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(2 * BIT);
    check("after_bad_addr", 32'(last_addr), 1);
    check("after_bad_din", 32'(last_din), 32'h7E);
    check("after_bad_pending", exp_q.size(), 0);

    // 16 back-to-back bytes fill memory; a 17th wraps to 0 while byte_cnt saturates.
    do_reset("rst2");
    w0 = n_writes;
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, 1'b0);
    idle(2 * BIT);
    check("b2b_writes", n_writes - w0, 16);
    check("b2b_byte_cnt", 32'(byte_cnt), 16);
    check("b2b_last_addr", 32'(last_addr), 15);
    check("b2b_last_din", 32'(last_din), 32'h0F);
    send_frame(8'h99, 1'b1, 1'b0);
    idle(2 * BIT);
    check("wrap_addr", 32'(last_addr), 0);
    check("wrap_din", 32'(last_din), 32'h99);
    check("wrap_byte_cnt", 32'(byte_cnt), 16);
    check("wrap_pending", exp_q.size(), 0);

    // Reset during bit 4 of a frame: partial byte dropped, next byte goes to address 0.
    @(negedge sys_clk);
    rx = 1'b0;
    repeat (BIT - 1) @(negedge sys_clk);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hF0 >> i));
    @(negedge sys_clk);
    rx = 1'b1;
    repeat (BIT / 2) @(negedge sys_clk);
    do_reset("midrst");
    idle(2 * BIT);
    w0 = n_writes;
    send_frame(8'h55, 1'b1, 1'b0);
    idle(2 * BIT);
    check("midrst_writes", n_writes - w0, 1);
    check("midrst_addr", 32'(last_addr), 0);
    check("midrst_din", 32'(last_din), 32'h55);
    check("midrst_byte_cnt", 32'(byte_cnt), 1);

`ifdef UART_RX_PARITY_EN
    w0 = n_writes;
    e0 = n_errs;
    send_frame(8'h01, 1'b1, 1'b1);
    idle(2 * BIT);
    check("par_bad_errs", n_errs - e0, 1);
    check("par_bad_writes", n_writes - w0, 0);
    send_frame(8'h03, 1'b1, 1'b0);
    idle(2 * BIT);
    check("par_good_addr", 32'(last_addr), 1);
    check("par_good_din", 32'(last_din), 32'h03);
`endif

    check("final_pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
